ps2_scan_ctrl: RTL and testbench

//  Sequences raw bytes from the PS/2 byte receiver into complete key events {code, ext, brk}.
//  - Tracks the E0 (extended) and F0 (break) prefixes.
//  - Times out stalled prefix sequences.
//  - Buffers decoded events in a small FIFO with a valid/ready handshake toward the consumer.
//  - Sits between the PS/2 receiver (rx_done_tick, 8-bit data) and application logic.

---
 rtl/ps2_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: turns the raw PS/2 byte stream into {code, ext, brk} key
// events. E0/F0 prefixes are folded into flags on the following scan code,
// a stalled prefix times out, and finished events queue in a small FIFO
// drained through a valid/ready handshake.
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH  = 4,       // power of 2, >= 2
    parameter int TIMEOUT_CYC = 200000   // >= 2
) (
    input  logic                          clk,
    input  logic                          reset,        // async, active low
    input  logic                          rx_done_tick,
    input  logic [7:0]                    din,
    input  logic                          key_ready,
    input  logic                          ovf_clr,
    output logic                          key_valid,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_brk,
    output logic                          overflow,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;

    // ---------------------------------------------------------------
    // Decoder state
    // ---------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          is_ctrl;
    logic          push;
    logic [9:0]    push_ev;     // {code, ext, brk}

    // Keyboard status/ack bytes are never part of a key sequence.
    always_comb begin
        is_ctrl = (din == 8'hAA) || (din == 8'hFA) || (din == 8'hEE) ||
                  (din == 8'hFE) || (din == 8'h00) || (din == 8'hFF);
    end

    // Prefix tracking and timeout; a byte arriving on the expiry cycle wins.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        push    = 1'b0;
        push_ev = {din, 2'b00};
        if (rx_done_tick) begin
            tmo_d = '0;
            if (is_ctrl) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (din == B_EXT)      state_d = S_EXT;
                        else if (din == B_BRK) state_d = S_BRK;
                        else begin
                            push    = 1'b1;
                            push_ev = {din, 1'b0, 1'b0};
                        end
                    end
                    S_EXT: begin
                        if (din == B_BRK)      state_d = S_EXT_BRK;
                        else if (din == B_EXT) state_d = S_EXT;
                        else begin
                            push    = 1'b1;
                            push_ev = {din, 1'b1, 1'b0};
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (din == B_BRK)      state_d = S_BRK;
                        else if (din == B_EXT) state_d = S_EXT;
                        else begin
                            push    = 1'b1;
                            push_ev = {din, 1'b0, 1'b1};
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        if (din == B_BRK)      state_d = S_EXT_BRK;
                        else if (din == B_EXT) state_d = S_EXT;
                        else begin
                            push    = 1'b1;
                            push_ev = {din, 1'b1, 1'b1};
                            state_d = S_IDLE;
                        end
                    end
                endcase
            end
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Decoder registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------
    logic [FIFO_DEPTH-1:0][9:0] mem_q;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic                       pop, full, do_push, drop;
    logic [AW-1:0]              head_idx;

    // A pop frees the slot this cycle, so a push into a full FIFO still
    // lands when the consumer takes the head at the same time.
    always_comb begin
        pop      = (count_q != '0) && key_ready;
        full     = (count_q == CW'(FIFO_DEPTH));
        do_push  = push && (!full || pop);
        drop     = push && full && !pop;
        count_d  = count_q + CW'(do_push) - CW'(pop);
        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        // When empty, rd_ptr-1 is the entry that was popped last.
        head_idx = (count_q == '0) ? (rd_ptr_q - AW'(1)) : rd_ptr_q;
    end

    // FIFO storage, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_ev;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from registers; no input-to-output paths.
    always_comb begin
        key_valid  = (count_q != '0);
        key_code   = mem_q[head_idx][9:2];
        key_ext    = mem_q[head_idx][1];
        key_brk    = mem_q[head_idx][0];
        overflow   = ovf_q;
        err        = err_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: directed scenarios with literal
// expectations, then a long randomized run, all mirrored by a queue-based
// model that a negedge process compares against every cycle.
module tb_ps2_scan_ctrl;

    localparam int D = 4;
    localparam int T = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       key_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       key_valid, key_ext, key_brk, overflow, err;
    logic [7:0] key_code;
    logic [$clog2(D):0] fifo_count;

    ps2_scan_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
        .key_ready(key_ready), .ovf_clr(ovf_clr), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
        .overflow(overflow), .err(err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // model: pending prefix flags, stall timer, event queue
    logic [9:0] mq[$];
    bit m_ext, m_brk, m_err, m_ovf;
    int m_tmo;

    logic [7:0] ctl_bytes [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_ctl(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_err = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit tk, input logic [7:0] d, input bit rdy, input bit clr);
        bit push = 0;
        bit drop = 0;
        bit pend = m_ext | m_brk;
        logic [9:0] ev = '0;
        m_err = 0;
        if (tk) begin
            m_tmo = 0;
            if (is_ctl(d)) begin
                m_ext = 0; m_brk = 0; m_err = 1;
            end else if (d == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else begin
                push = 1; ev = {d, m_ext, m_brk};
                m_ext = 0; m_brk = 0;
            end
        end else if (!pend) begin
            m_tmo = 0;
        end else if (m_tmo == T - 1) begin
            m_ext = 0; m_brk = 0; m_tmo = 0; m_err = 1;
        end else begin
            m_tmo++;
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < D) mq.push_back(ev);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    // one clock: drive inputs, let the edge happen, advance the model
    task automatic cyc(input bit tk, input logic [7:0] d, input bit rdy, input bit clr);
        rx_done_tick = tk; din = d; key_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        #1;
        if (reset) model_step(tk, d, rdy, clr);
        rx_done_tick = 0; ovf_clr = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, rdy, 0);
    endtask

    task automatic chk_head(input string nm, input logic [9:0] exp);
        chk({nm, " valid"}, key_valid, 1);
        chk({nm, " head"}, {key_code, key_ext, key_brk}, exp);
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on && reset) begin
            chk("m valid", key_valid, mq.size() > 0);
            chk("m count", fifo_count, mq.size());
            chk("m overflow", overflow, m_ovf);
            chk("m err", err, m_err);
            if (mq.size() > 0) chk("m head", {key_code, key_ext, key_brk}, mq[0]);
        end
    end

    initial begin
        logic [7:0] drain_exp [4];
        logic [7:0] r;
        int rate;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", key_valid, 0);
        chk("rst code", key_code, 8'h00);
        chk("rst ext/brk", {key_ext, key_brk}, 2'b00);
        chk("rst ovf", overflow, 0);
        chk("rst err", err, 0);
        chk("rst count", fifo_count, 0);
        reset = 1;
        chk_on = 1;
        idle(2, 0);

        // 1: single make code, next-cycle visibility, then consumed
        cyc(1, 8'h1C, 1, 0);
        chk_head("t1", {8'h1C, 2'b00});
        idle(1, 1);
        chk("t1 empty", key_valid, 0);

        // 2: break prefix folds into one event
        cyc(1, 8'hF0, 0, 0);
        chk("t2 after F0", fifo_count, 0);
        cyc(1, 8'h1C, 0, 0);
        chk("t2 count", fifo_count, 1);
        chk_head("t2", {8'h1C, 2'b01});
        idle(1, 1);

        // 3: extended break and extended make
        cyc(1, 8'hE0, 0, 0);
        cyc(1, 8'hF0, 0, 0);
        cyc(1, 8'h75, 0, 0);
        chk_head("t3a", {8'h75, 2'b11});
        cyc(1, 8'hE0, 0, 0);
        cyc(1, 8'h6B, 0, 0);
        chk("t3 count", fifo_count, 2);
        chk("t3 err", err, 0);
        idle(1, 1);
        chk_head("t3b", {8'h6B, 2'b10});
        idle(1, 1);

        // 4: overflow, push+pop while full, drain order, clear
        cyc(1, 8'h15, 0, 0);
        cyc(1, 8'h1D, 0, 0);
        cyc(1, 8'h24, 0, 0);
        cyc(1, 8'h2D, 0, 0);
        cyc(1, 8'h2C, 0, 0);
        chk("t4 count full", fifo_count, 4);
        chk("t4 ovf", overflow, 1);
        chk_head("t4 head", {8'h15, 2'b00});
        cyc(1, 8'h3C, 1, 0);
        chk("t4 push+pop count", fifo_count, 4);
        drain_exp = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            chk_head("t4 drain", {drain_exp[i], 2'b00});
            cyc(0, 8'h00, 1, 0);
        end
        chk("t4 drained", fifo_count, 0);
        chk("t4 ovf held", overflow, 1);
        cyc(0, 8'h00, 0, 1);
        chk("t4 ovf clr", overflow, 0);
        // drop coincident with clear: set wins
        for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
        cyc(1, 8'h50, 0, 1);
        chk("t4 set wins", overflow, 1);
        cyc(0, 8'h00, 0, 1);
        chk("t4 ovf clr2", overflow, 0);
        idle(5, 1);

        // 5: prefix timeout, then normal decode, then a control byte
        cyc(1, 8'hE0, 0, 0);
        idle(T - 1, 0);
        chk("t5 err early", err, 0);
        idle(1, 0);
        chk("t5 err pulse", err, 1);
        idle(1, 0);
        chk("t5 err one cycle", err, 0);
        cyc(1, 8'h1C, 0, 0);
        chk_head("t5 after tmo", {8'h1C, 2'b00});
        cyc(1, 8'hAA, 0, 0);
        chk("t5 ctl err", err, 1);
        chk("t5 ctl no push", fifo_count, 1);
        idle(2, 1);
        // byte on the expiry cycle is decoded, no err
        cyc(1, 8'hE0, 0, 0);
        idle(T - 1, 0);
        cyc(1, 8'h1C, 0, 0);
        chk("t5 race err", err, 0);
        chk_head("t5 race", {8'h1C, 2'b10});
        idle(2, 1);

        // 6: reset mid-prefix with events buffered
        cyc(1, 8'h1C, 0, 0);
        cyc(1, 8'h32, 0, 0);
        cyc(1, 8'hF0, 0, 0);
        idle(3, 0);
        reset = 0;
        model_reset();
        #1;
        chk("t6 rst valid", key_valid, 0);
        chk("t6 rst count", fifo_count, 0);
        idle(2, 0);
        reset = 1;
        cyc(1, 8'h1C, 0, 0);
        chk_head("t6 after rst", {8'h1C, 2'b00});
        idle(2, 1);

        // randomized traffic, varying tick density so timeouts occur
        for (int blk = 0; blk < 30; blk++) begin
            rate = $urandom_range(1, 60);
            for (int i = 0; i < 200; i++) begin
                case ($urandom_range(0, 9))
                    0, 1:    r = 8'hE0;
                    2, 3:    r = 8'hF0;
                    4:       r = ctl_bytes[$urandom_range(0, 5)];
                    default: r = 8'($urandom_range(0, 255));
                endcase
                cyc($urandom_range(1, rate) == 1, r,
                    (blk % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0),
                    $urandom_range(0, 25) == 0);
            end
        end

        idle(2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
